// File: rtl/issue_fu_fifo_pkg.sv
// Helpers shared by the issue-to-FU FIFO and its lane compactor.
package issue_fu_fifo_pkg;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared processor definitions: issue-to-FU packet format and issue queue sizing.
`ifndef IS_FIFO_DEPTH
`define IS_FIFO_DEPTH sys_defs::IS_FIFO_DEPTH_P
`endif

package sys_defs;

  localparam int IS_FIFO_DEPTH_P = 8;

  typedef struct packed {
    logic        valid;
    logic [3:0]  fu_op;
    logic [5:0]  dest_prn;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } ISSUE_FU_PACKET;

endpackage

// File: rtl/issue_fu_fifo_lane_compact.sv
// Turns a lane mask into an ordered index list (highest set lane first) plus its popcount.
module lane_compact
  import issue_fu_fifo_pkg::*;
#(
  parameter  int W     = 3,
  localparam int IDX_W = lane_idx_w(W),
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]            mask_i,
  output logic [W-1:0][IDX_W-1:0] idx_o,
  output logic [CNT_W-1:0]        cnt_o
);

  logic [CNT_W-1:0] n;

  always_comb begin
    idx_o = '0;
    n     = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o[n] = IDX_W'(i);
        n        = n + CNT_W'(1);
      end
    end
    cnt_o = n;
  end

endmodule

// File: rtl/issue_fu_fifo.sv
// Multi-lane circular FIFO between issue and a functional unit, with same-cycle write-through pops.
`ifndef IS_FIFO_DEPTH
`define IS_FIFO_DEPTH sys_defs::IS_FIFO_DEPTH_P
`endif

module issue_fu_fifo
  import sys_defs::*;
  import issue_fu_fifo_pkg::*;
#(
  parameter int DEPTH     = `IS_FIFO_DEPTH,
  parameter int WIDTH     = 3,
  parameter int AF_MARGIN = WIDTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       squash,
  input  ISSUE_FU_PACKET [WIDTH-1:0] fu_pckt_in,
  input  logic [WIDTH-1:0]           rd_EN,
  output ISSUE_FU_PACKET [WIDTH-1:0] fu_pckt_out,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
`ifdef TEST_MODE
  ,
  output ISSUE_FU_PACKET [DEPTH-1:0] fifo_display
`endif
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = lane_idx_w(DEPTH);
  localparam int LCNT_W = $clog2(WIDTH + 1);
  localparam int LIDX_W = lane_idx_w(WIDTH);
  localparam int EXT_W  = CNT_W + 1;

  localparam logic [EXT_W-1:0] DEPTH_X = EXT_W'(DEPTH);
  localparam logic [EXT_W-1:0] FULL_TH = EXT_W'(WIDTH);
  localparam logic [EXT_W-1:0] AF_TH   = EXT_W'(WIDTH + AF_MARGIN);

  // Offsets never exceed one lap, so a single conditional subtract wraps the pointer.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [EXT_W-1:0] off);
    logic [EXT_W-1:0] s;
    s = EXT_W'(p) + off;
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  ISSUE_FU_PACKET               mem_q [DEPTH];

  logic [WIDTH-1:0]             wr_valid;
  logic [WIDTH-1:0][LIDX_W-1:0] wr_idx, rd_idx;
  logic [LCNT_W-1:0]            wr_raw, rd_req;
  logic [EXT_W-1:0]             wr_req_x, rd_cnt, wr_acc, free_now, cnt_next;
  logic                         active;
  logic [WIDTH-1:0]             wr_en;
  logic [WIDTH-1:0][PTR_W-1:0]  wr_addr;
  ISSUE_FU_PACKET [WIDTH-1:0]   wr_data;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) wr_valid[i] = fu_pckt_in[i].valid;
  end

  lane_compact #(.W(WIDTH)) u_push_compact (
    .mask_i (wr_valid),
    .idx_o  (wr_idx),
    .cnt_o  (wr_raw)
  );

  lane_compact #(.W(WIDTH)) u_pop_compact (
    .mask_i (rd_EN),
    .idx_o  (rd_idx),
    .cnt_o  (rd_req)
  );

  // Pops may consume same-cycle pushes; pushes may reuse slots freed by this cycle's pops.
  always_comb begin : alloc
    logic [EXT_W-1:0] cnt_x, rd_x, avail;
    active   = reset_n & ~squash;
    cnt_x    = EXT_W'(count_q);
    wr_req_x = active ? EXT_W'(wr_raw) : '0;
    rd_x     = active ? EXT_W'(rd_req) : '0;
    avail    = cnt_x + wr_req_x;
    rd_cnt   = (rd_x < avail) ? rd_x : avail;
    free_now = DEPTH_X - cnt_x + rd_cnt;
    wr_acc   = (wr_req_x < free_now) ? wr_req_x : free_now;
    cnt_next = cnt_x + wr_acc - rd_cnt;
  end

  always_comb begin : pop_path
    logic [EXT_W-1:0]  k;
    logic [LIDX_W-1:0] woff;
    k           = '0;
    woff        = '0;
    fu_pckt_out = '0;
    for (int j = 0; j < WIDTH; j++) begin
      k    = EXT_W'(j);
      woff = LIDX_W'(k - EXT_W'(count_q));
      if (k < rd_cnt) begin
        if (k < EXT_W'(count_q)) fu_pckt_out[rd_idx[j]] = mem_q[ptr_add(head_q, k)];
        else                     fu_pckt_out[rd_idx[j]] = fu_pckt_in[wr_idx[woff]];
      end
    end
  end

  always_comb begin : push_path
    for (int j = 0; j < WIDTH; j++) begin
      wr_en[j]   = EXT_W'(j) < wr_acc;
      wr_addr[j] = ptr_add(tail_q, EXT_W'(j));
      wr_data[j] = fu_pckt_in[wr_idx[j]];
    end
  end

  always_comb begin : next_state
    logic [EXT_W-1:0] occ_d, free_d;
    head_d = head_q;
    tail_d = tail_q;
    ovf_d  = ovf_q;
    occ_d  = '0;
    if (squash) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = ptr_add(head_q, rd_cnt);
      tail_d = ptr_add(tail_q, wr_acc);
      occ_d  = cnt_next;
      ovf_d  = ovf_q | (wr_req_x > free_now);
    end
    count_d = occ_d[CNT_W-1:0];
    free_d  = DEPTH_X - occ_d;
    full_d  = free_d < FULL_TH;
    afull_d = free_d < AF_TH;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      for (int j = 0; j < WIDTH; j++) begin
        if (wr_en[j]) mem_q[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  assign count       = count_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;

`ifdef TEST_MODE
  always_comb begin
    for (int i = 0; i < DEPTH; i++) fifo_display[i] = mem_q[i];
  end
`endif

endmodule
